// File: rtl/eth_pkg.sv
// Shared Ethernet definitions: EtherTypes, broadcast MAC, header bit
// offsets inside the 256-bit beat (byte 0 at [255:248]), RX filter FSM states.
package eth_pkg;

    localparam logic [15:0] ETHERTYPE_IPV4 = 16'h0800;
    localparam logic [15:0] ETHERTYPE_ARP  = 16'h0806;
    localparam logic [47:0] BCAST_MAC      = 48'hFFFF_FFFF_FFFF;

    localparam int BEAT_W     = 256;
    localparam int EMPTY_W    = 5;
    localparam int DMAC_HI    = 255;
    localparam int DMAC_LO    = 208;
    localparam int ETYPE_HI   = 159;
    localparam int ETYPE_LO   = 144;

    // An SOP+EOP beat with more empty bytes than this carries < 14 bytes,
    // i.e. not even a full Ethernet header.
    localparam logic [EMPTY_W-1:0] RUNT_EMPTY_MAX = 5'd18;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PASS = 2'd1,
        ST_DROP = 2'd2
    } rx_state_t;

endpackage

// File: rtl/eth_rx_header_match.sv
// Combinational header check on an SOP beat: destination/EtherType match
// and runt detection. The caller only consults it on SOP beats in IDLE.
module eth_rx_header_match
    import eth_pkg::*;
#(
    parameter logic [47:0] MAC_ADDR         = 48'h02AB_CD00_0102,
    parameter bit          ACCEPT_BROADCAST = 1'b1
) (
    input  logic [BEAT_W-1:0]  data_i,
    input  logic               eop_i,
    input  logic [EMPTY_W-1:0] empty_i,
    output logic               match_o,
    output logic               runt_o
);

    logic [47:0] dest;
    logic [15:0] etype;
    logic        dest_ok;
    logic        type_ok;

    assign dest  = data_i[DMAC_HI:DMAC_LO];
    assign etype = data_i[ETYPE_HI:ETYPE_LO];

    // Address and protocol filters; runt overrides both in the top.
    always_comb begin
        dest_ok = (dest == MAC_ADDR) || (ACCEPT_BROADCAST && (dest == BCAST_MAC));
        type_ok = (etype == ETHERTYPE_IPV4) || (etype == ETHERTYPE_ARP);
        match_o = dest_ok && type_ok;
        runt_o  = eop_i && (empty_i > RUNT_EMPTY_MAX);
    end

endmodule

// File: rtl/eth_rx_frame_filter.sv
// RX frame filter: forwards whole frames addressed to this station (unicast
// or broadcast, ARP/IPv4), drops everything else. One registered output
// stage with full backpressure; in_ready is the only combinational path.
// Optional frame counters: define ETH_RX_FRAME_FILTER_STATS_EN.
module eth_rx_frame_filter
    import eth_pkg::*;
#(
    parameter logic [47:0] MAC_ADDR         = 48'h02AB_CD00_0102,
    parameter bit          ACCEPT_BROADCAST = 1'b1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [BEAT_W-1:0]  in_data,
    input  logic               in_valid,
    input  logic               in_startofpacket,
    input  logic               in_endofpacket,
    input  logic [EMPTY_W-1:0] in_empty,
    output logic               in_ready,
    output logic [BEAT_W-1:0]  out_data,
    output logic               out_valid,
    output logic               out_startofpacket,
    output logic               out_endofpacket,
    output logic [EMPTY_W-1:0] out_empty,
    input  logic               out_ready,
    output logic [31:0]        stat_accepted,
    output logic [31:0]        stat_dropped
);

    rx_state_t          state_q;
    logic [BEAT_W-1:0]  out_data_q;
    logic               out_valid_q;
    logic               out_sop_q;
    logic               out_eop_q;
    logic [EMPTY_W-1:0] out_empty_q;

    logic hdr_match;
    logic hdr_runt;
    logic hdr_accept;
    logic xfer;
    logic fwd;

    eth_rx_header_match #(
        .MAC_ADDR         (MAC_ADDR),
        .ACCEPT_BROADCAST (ACCEPT_BROADCAST)
    ) u_hdr (
        .data_i  (in_data),
        .eop_i   (in_endofpacket),
        .empty_i (in_empty),
        .match_o (hdr_match),
        .runt_o  (hdr_runt)
    );

    assign hdr_accept = hdr_match && !hdr_runt;
    assign in_ready   = !out_valid_q || out_ready;
    assign xfer       = in_valid && in_ready;

    // A beat is forwarded when it opens an accepted frame or belongs to one.
    assign fwd = xfer && (((state_q == ST_IDLE) && in_startofpacket && hdr_accept) ||
                          (state_q == ST_PASS));

    // Frame FSM plus the output register; the register only moves on a
    // forwarded transfer or when its beat is taken, so it holds under stall.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sop_q   <= 1'b0;
            out_eop_q   <= 1'b0;
            out_empty_q <= '0;
        end else begin
            if (fwd) begin
                out_valid_q <= 1'b1;
                out_data_q  <= in_data;
                out_sop_q   <= in_startofpacket;
                out_eop_q   <= in_endofpacket;
                out_empty_q <= in_endofpacket ? in_empty : '0;
            end else if (out_ready) begin
                out_valid_q <= 1'b0;
            end

            if (xfer) begin
                case (state_q)
                    ST_IDLE: begin
                        // Single-beat frames and stray beats leave us in IDLE.
                        if (in_startofpacket && !in_endofpacket)
                            state_q <= hdr_accept ? ST_PASS : ST_DROP;
                    end
                    ST_PASS, ST_DROP: begin
                        if (in_endofpacket)
                            state_q <= ST_IDLE;
                    end
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    assign out_data          = out_data_q;
    assign out_valid         = out_valid_q;
    assign out_startofpacket = out_sop_q;
    assign out_endofpacket   = out_eop_q;
    assign out_empty         = out_empty_q;

`ifdef ETH_RX_FRAME_FILTER_STATS_EN
    logic [31:0] acc_q, acc_d;
    logic [31:0] drop_q, drop_d;
    logic        idle_xfer;

    assign idle_xfer = xfer && (state_q == ST_IDLE);

    // Every IDLE transfer is exactly one accept or one drop event.
    always_comb begin
        acc_d  = acc_q;
        drop_d = drop_q;
        if (idle_xfer) begin
            if (in_startofpacket && hdr_accept)
                acc_d = acc_q + 32'd1;
            else
                drop_d = drop_q + 32'd1;
        end
    end

    // Free-running wrapping counters.
    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q  <= '0;
            drop_q <= '0;
        end else begin
            acc_q  <= acc_d;
            drop_q <= drop_d;
        end
    end

    assign stat_accepted = acc_q;
    assign stat_dropped  = drop_q;
`else
    assign stat_accepted = '0;
    assign stat_dropped  = '0;
`endif

endmodule
